alu_multicycle: RTL and testbench

Parametrised successor to the single-cycle 32-bit ALU. It executes single-cycle arithmetic, logic and shift operations, plus multi-cycle multiply and optional divide, behind a start/done handshake. Results are registered into Lo/Hi result registers. It sits in the EX stage and stalls the pipeline through `Busy` while an iterative operation runs.

---
 rtl/alu_multicycle.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// alu_multicycle: EX-stage ALU that has single-cycle arithmetic, logic and shift ops,
// an iterative shift-add multiplier and an optional restoring divider. All three sit
// behind a Start/Done handshake. Results are held in Lo (ALUResult) and Hi
// (ALUResultHi) registers.
// Optional feature: define ALU_DIV_EN to compile in the divider (DIV/FIX states).
module alu_multicycle #(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [4:0]       ALUControl,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] ALUResult,
   output logic [WIDTH-1:0] ALUResultHi,
   output logic             Zero,
   output logic             Busy,
   output logic             Done
);
   localparam int SHW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0]   ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0]   ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0]   ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [2*WIDTH-1:0] ONE2 = {{(2*WIDTH-1){1'b0}}, 1'b1};
   localparam logic [SHW-1:0]     LAST = SHW'(WIDTH - 1);
   localparam logic [SHW-1:0]     CNT1 = {{(SHW-1){1'b0}}, 1'b1};

   localparam logic [4:0] OP_ADD  = 5'd0;
   localparam logic [4:0] OP_SUB  = 5'd1;
   localparam logic [4:0] OP_MUL  = 5'd2;
   localparam logic [4:0] OP_MULU = 5'd3;
   localparam logic [4:0] OP_DIV  = 5'd4;
   localparam logic [4:0] OP_AND  = 5'd8;
   localparam logic [4:0] OP_OR   = 5'd9;
   localparam logic [4:0] OP_NOR  = 5'd10;
   localparam logic [4:0] OP_XOR  = 5'd11;
   localparam logic [4:0] OP_SLL  = 5'd12;
   localparam logic [4:0] OP_SRL  = 5'd13;
   localparam logic [4:0] OP_SLT  = 5'd14;
   localparam logic [4:0] OP_SLTU = 5'd15;
   localparam logic [4:0] OP_SRA  = 5'd16;

`ifdef ALU_DIV_EN
   localparam logic [4:0]       OP_DIVU = 5'd5;
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_FIX = 2'd3} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1} state_t;
`endif

   // Two's complement negate
   function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
      return ~x + ONE;
   endfunction

   // Magnitude of a value whose sign has already been decided
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
      return sgn ? neg(x) : x;
   endfunction

   state_t              state, next_state;
   logic [SHW-1:0]      cnt;
   logic                last;
   logic [2*WIDTH-1:0]  prod;
   logic [WIDTH-1:0]    mcand;
   logic                mneg;

   logic [WIDTH-1:0]    sc_lo, sc_hi;
   logic                sc_hi_we, req_mul, a_neg, b_neg;
   logic [SHW-1:0]      sh;

   logic [WIDTH:0]      mul_sum;
   logic [2*WIDTH-1:0]  mul_next, mul_final;

`ifdef ALU_DIV_EN
   logic                req_div;
   logic [WIDTH-1:0]    rem, quo, dvsr;
   logic                qneg, rneg;
   logic [WIDTH-1:0]    div_shift, div_diff, rem_next, quo_next, fix_lo, fix_hi;
   logic                div_ok;
`endif

   assign sh   = B[SHW-1:0];
   assign last = (cnt == LAST);

   // Decode the opcode: single-cycle result, special divide cases, and iterative requests
   always_comb begin
      sc_lo    = ONES;
      sc_hi    = ZERO;
      sc_hi_we = 1'b0;
      req_mul  = 1'b0;
`ifdef ALU_DIV_EN
      req_div  = 1'b0;
`endif
      a_neg = ((ALUControl == OP_MUL) || (ALUControl == OP_DIV)) & A[WIDTH-1];
      b_neg = ((ALUControl == OP_MUL) || (ALUControl == OP_DIV)) & B[WIDTH-1];
      case (ALUControl)
         OP_ADD:          sc_lo = A + B;
         OP_SUB:          sc_lo = A - B;
         OP_MUL, OP_MULU: req_mul = 1'b1;
`ifdef ALU_DIV_EN
         OP_DIV, OP_DIVU: begin
            if (B == ZERO) begin
               sc_lo    = ONES;
               sc_hi    = A;
               sc_hi_we = 1'b1;
            end else if ((ALUControl == OP_DIV) && (A == MIN_NEG) && (B == ONES)) begin
               sc_lo    = MIN_NEG;
               sc_hi    = ZERO;
               sc_hi_we = 1'b1;
            end else begin
               req_div  = 1'b1;
            end
         end
`endif
         OP_AND:  sc_lo = A & B;
         OP_OR:   sc_lo = A | B;
         OP_NOR:  sc_lo = ~(A | B);
         OP_XOR:  sc_lo = A ^ B;
         OP_SLL:  sc_lo = A << sh;
         OP_SRL:  sc_lo = A >> sh;
         OP_SRA:  sc_lo = $unsigned($signed(A) >>> sh);
         OP_SLT:  sc_lo = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         OP_SLTU: sc_lo = {{(WIDTH-1){1'b0}}, (A < B)};
         default: begin
            sc_lo    = ONES;
            sc_hi    = ZERO;
            sc_hi_we = 1'b1;
         end
      endcase
   end

   // One shift-add multiply step; the final step also produces the sign-corrected product
   always_comb begin
      mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : {1'b0, ZERO});
      mul_next = {mul_sum, prod[WIDTH-1:1]};
      if (mneg) begin
         mul_final = ~mul_next + ONE2;
      end else begin
         mul_final = mul_next;
      end
   end

`ifdef ALU_DIV_EN
   // One restoring divide step; rem's top bit set means the shifted value already exceeds dvsr
   always_comb begin
      div_shift = {rem[WIDTH-2:0], quo[WIDTH-1]};
      div_diff  = div_shift - dvsr;
      div_ok    = rem[WIDTH-1] | (div_shift >= dvsr);
      if (div_ok) begin
         rem_next = div_diff;
         quo_next = {quo[WIDTH-2:0], 1'b1};
      end else begin
         rem_next = div_shift;
         quo_next = {quo[WIDTH-2:0], 1'b0};
      end
      fix_lo = qneg ? neg(quo) : quo;
      fix_hi = rneg ? neg(rem) : rem;
   end
`endif

   // Next-state logic; Start is only looked at in IDLE
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (Start && req_mul) begin
               next_state = S_MUL;
`ifdef ALU_DIV_EN
            end else if (Start && req_div) begin
               next_state = S_DIV;
`endif
            end else begin
               next_state = S_IDLE;
            end
         end
         S_MUL: begin
            if (last) begin
               next_state = S_IDLE;
            end else begin
               next_state = S_MUL;
            end
         end
`ifdef ALU_DIV_EN
         S_DIV: begin
            if (last) begin
               next_state = S_FIX;
            end else begin
               next_state = S_DIV;
            end
         end
         S_FIX:   next_state = S_IDLE;
`endif
         default: next_state = S_IDLE;
      endcase
   end

   // State register and Busy flag, which is high for every non-IDLE cycle
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= S_IDLE;
         Busy  <= 1'b0;
      end else begin
         state <= next_state;
         Busy  <= (next_state != S_IDLE);
      end
   end

   // Datapath: operand latching, iteration registers, result registers and Done pulse
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         cnt         <= {SHW{1'b0}};
         prod        <= {(2*WIDTH){1'b0}};
         mcand       <= ZERO;
         mneg        <= 1'b0;
`ifdef ALU_DIV_EN
         rem         <= ZERO;
         quo         <= ZERO;
         dvsr        <= ZERO;
         qneg        <= 1'b0;
         rneg        <= 1'b0;
`endif
         ALUResult   <= ZERO;
         ALUResultHi <= ZERO;
         Zero        <= 1'b1;
         Done        <= 1'b0;
      end else begin
         Done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (Start) begin
                  if (req_mul) begin
                     prod  <= {ZERO, mag(B, b_neg)};
                     mcand <= mag(A, a_neg);
                     mneg  <= a_neg ^ b_neg;
                     cnt   <= {SHW{1'b0}};
`ifdef ALU_DIV_EN
                  end else if (req_div) begin
                     quo   <= mag(A, a_neg);
                     rem   <= ZERO;
                     dvsr  <= mag(B, b_neg);
                     qneg  <= a_neg ^ b_neg;
                     rneg  <= a_neg;
                     cnt   <= {SHW{1'b0}};
`endif
                  end else begin
                     ALUResult <= sc_lo;
                     if (sc_hi_we) begin
                        ALUResultHi <= sc_hi;
                     end
                     Zero <= (sc_lo == ZERO);
                     Done <= 1'b1;
                  end
               end
            end
            S_MUL: begin
               prod <= mul_next;
               cnt  <= cnt + CNT1;
               if (last) begin
                  ALUResult   <= mul_final[WIDTH-1:0];
                  ALUResultHi <= mul_final[2*WIDTH-1:WIDTH];
                  Zero        <= (mul_final[WIDTH-1:0] == ZERO);
                  Done        <= 1'b1;
               end
            end
`ifdef ALU_DIV_EN
            S_DIV: begin
               rem <= rem_next;
               quo <= quo_next;
               cnt <= cnt + CNT1;
            end
            S_FIX: begin
               ALUResult   <= fix_lo;
               ALUResultHi <= fix_hi;
               Zero        <= (fix_lo == ZERO);
               Done        <= 1'b1;
            end
`endif
            default: begin
               Done <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle (WIDTH=32): directed vectors push expected
// Lo/Hi and the cycle in which Done must appear; a monitor pops on every Done.
module tb_alu_multicycle;
   localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_MUL = 5'd2,  OP_MULU = 5'd3;
   localparam logic [4:0] OP_DIV = 5'd4,  OP_DIVU = 5'd5, OP_AND = 5'd8,  OP_OR = 5'd9;
   localparam logic [4:0] OP_NOR = 5'd10, OP_XOR = 5'd11, OP_SLL = 5'd12, OP_SRL = 5'd13;
   localparam logic [4:0] OP_SLT = 5'd14, OP_SLTU = 5'd15, OP_SRA = 5'd16;

   logic        clk = 1'b0;
   logic        Reset, Start;
   logic [4:0]  ALUControl;
   logic [31:0] A, B, ALUResult, ALUResultHi;
   logic        Zero, Busy, Done;

   typedef struct {
      logic [31:0] lo;
      logic [31:0] hi;
      int          due;
      string       nm;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   int   n_expected = 0;
   int   done_cnt = 0;
   int   busy_cnt;

   alu_multicycle #(.WIDTH(32)) dut (
      .Clk(clk), .Reset(Reset), .Start(Start), .ALUControl(ALUControl),
      .A(A), .B(B), .ALUResult(ALUResult), .ALUResultHi(ALUResultHi),
      .Zero(Zero), .Busy(Busy), .Done(Done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Monitor: every Done must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (!Reset && Done) begin
         done_cnt++;
         if (sb.size() == 0) begin
            check("unexpected_done", 64'(ALUResult), 64'(32'hX));
         end else begin
            mon_e = sb.pop_front();
            check({mon_e.nm, "_lo"},   64'(ALUResult),   64'(mon_e.lo));
            check({mon_e.nm, "_hi"},   64'(ALUResultHi), 64'(mon_e.hi));
            check({mon_e.nm, "_zero"}, 64'(Zero),        64'(mon_e.lo == 32'd0));
            check({mon_e.nm, "_lat"},  64'(cyc),         64'(mon_e.due));
         end
      end
   end

   // Drive one request at the current negedge and advance to the next negedge (Start left high)
   task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] lo, input logic [31:0] hi,
                        input string nm);
      exp_t e;
      Start = 1'b1; ALUControl = op; A = a; B = b;
      e.lo = lo; e.hi = hi; e.due = cyc + lat; e.nm = nm;
      sb.push_back(e);
      n_expected++;
      @(negedge clk);
   endtask

   task automatic wait_drain(input int bound);
      int k = 0;
      while (sb.size() != 0 && k < bound) begin
         @(negedge clk);
         k++;
      end
      if (sb.size() != 0) begin
         check("drain_timeout", 64'(sb.size()), 64'd0);
         sb.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      Reset = 1'b1; Start = 1'b0; ALUControl = 5'd0; A = 32'd0; B = 32'd0;
      @(negedge clk);
      check("rst_lo",   64'(ALUResult),   64'd0);
      check("rst_hi",   64'(ALUResultHi), 64'd0);
      check("rst_zero", 64'(Zero),        64'd1);
      check("rst_busy", 64'(Busy),        64'd0);
      check("rst_done", 64'(Done),        64'd0);
      @(negedge clk);
      Reset = 1'b0;

      // Signed multiply; Start while busy and in the last MUL cycle must be ignored
      issue(OP_MUL, 32'hFFFFFFFD, 32'd7, 33, 32'hFFFFFFEB, 32'hFFFFFFFF, "mul_m3x7");
      Start = 1'b0; A = 32'hDEADBEEF; B = 32'h0; busy_cnt = 0;
      for (int i = 0; i < 32; i++) begin
         if (Busy) busy_cnt++;
         if (i == 3)  begin Start = 1'b1; ALUControl = OP_ADD; A = 32'd1; B = 32'd1; end
         if (i == 6)  Start = 1'b0;
         if (i == 31) begin Start = 1'b1; ALUControl = OP_ADD; A = 32'd5; B = 32'd5; end
         @(negedge clk);
      end
      Start = 1'b0;
      check("busy_cycles",     64'(busy_cnt), 64'd32);
      check("busy_low_at_done", 64'(Busy),    64'd0);
      wait_drain(10);

      // Back-to-back single-cycle ops; Hi must hold the mul's upper half
      issue(OP_ADD,  32'hFFFFFFFF, 32'd1,        1, 32'h00000000, 32'hFFFFFFFF, "add_wrap");
      issue(OP_SRA,  32'h80000000, 32'h24,       1, 32'hF8000000, 32'hFFFFFFFF, "sra");
      issue(OP_SUB,  32'd5,        32'd7,        1, 32'hFFFFFFFE, 32'hFFFFFFFF, "sub");
      issue(OP_AND,  32'hF0F01234, 32'h0FF0FF00, 1, 32'h00F01200, 32'hFFFFFFFF, "and");
      issue(OP_OR,   32'hF0F01234, 32'h0FF0FF00, 1, 32'hFFF0FF34, 32'hFFFFFFFF, "or");
      issue(OP_NOR,  32'hF0F01234, 32'h0FF0FF00, 1, 32'h000F00CB, 32'hFFFFFFFF, "nor");
      issue(OP_XOR,  32'hF0F01234, 32'h0FF0FF00, 1, 32'hFF00ED34, 32'hFFFFFFFF, "xor");
      issue(OP_SLL,  32'h00000001, 32'd31,       1, 32'h80000000, 32'hFFFFFFFF, "sll");
      issue(OP_SRL,  32'h80000000, 32'h21,       1, 32'h40000000, 32'hFFFFFFFF, "srl");
      issue(OP_SLT,  32'hFFFFFFFF, 32'd1,        1, 32'h00000001, 32'hFFFFFFFF, "slt");
      issue(OP_SLTU, 32'hFFFFFFFF, 32'd1,        1, 32'h00000000, 32'hFFFFFFFF, "sltu");
      issue(5'd6,    32'd3,        32'd4,        1, 32'hFFFFFFFF, 32'h00000000, "undef6");
      issue(5'd31,   32'd3,        32'd4,        1, 32'hFFFFFFFF, 32'h00000000, "undef31");
      Start = 1'b0;
      wait_drain(10);

      issue(OP_MULU, 32'hFFFFFFFF, 32'd2, 33, 32'hFFFFFFFE, 32'h00000001, "mulu");
      Start = 1'b0; wait_drain(50);
      issue(OP_MUL, 32'h80000000, 32'hFFFFFFFF, 33, 32'h80000000, 32'h00000000, "mul_minx_m1");
      Start = 1'b0; wait_drain(50);
      issue(OP_MUL, 32'd0, 32'd5, 33, 32'h00000000, 32'h00000000, "mul_zero");
      Start = 1'b0; wait_drain(50);

`ifdef ALU_DIV_EN
      issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 34, 32'hFFFFFFFD, 32'hFFFFFFFF, "div_m7_2");
      Start = 1'b0; wait_drain(50);
      issue(OP_DIVU, 32'd7, 32'd0, 1, 32'hFFFFFFFF, 32'd7, "divu_by0");
      issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000, 32'd0, "div_ovf");
      Start = 1'b0; wait_drain(10);
      issue(OP_DIVU, 32'd100, 32'd7, 34, 32'd14, 32'd2, "divu_100_7");
      Start = 1'b0; wait_drain(50);
      issue(OP_DIV, 32'd7, 32'hFFFFFFFE, 34, 32'hFFFFFFFD, 32'd1, "div_7_m2");
      Start = 1'b0; wait_drain(50);
`else
      issue(OP_DIV,  32'hFFFFFFF9, 32'd2,        1, 32'hFFFFFFFF, 32'd0, "div_off_m7_2");
      issue(OP_DIVU, 32'd7,        32'd0,        1, 32'hFFFFFFFF, 32'd0, "divu_off_by0");
      issue(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 32'd0, "div_off_ovf");
      issue(OP_DIVU, 32'd100,      32'd7,        1, 32'hFFFFFFFF, 32'd0, "divu_off_100_7");
      Start = 1'b0; wait_drain(10);
`endif

      // Reset five cycles into a multiply: outputs clear at once, no Done afterwards
      issue(OP_MULU, 32'h12345678, 32'd9, 33, 32'd0, 32'd0, "mulu_aborted");
      Start = 1'b0;
      repeat (5) @(negedge clk);
      #2 Reset = 1'b1;
      #1;
      check("abort_lo",   64'(ALUResult),   64'd0);
      check("abort_hi",   64'(ALUResultHi), 64'd0);
      check("abort_zero", 64'(Zero),        64'd1);
      check("abort_busy", 64'(Busy),        64'd0);
      check("abort_done", 64'(Done),        64'd0);
      sb.delete();
      n_expected--;
      @(negedge clk);
      Reset = 1'b0;
      repeat (40) @(negedge clk);

      issue(OP_ADD, 32'd2, 32'd3, 1, 32'd5, 32'd0, "add_after_rst");
      Start = 1'b0;
      wait_drain(10);
      check("done_count", 64'(done_cnt), 64'(n_expected));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
